// File: rtl/multi_debounce_pulser.sv
// Per-channel synchroniser, stability-counter debouncer and registered edge pulser.
// Optional auto-repeat on held inputs is built only when AUTO_REPEAT_EN is defined.
module multi_debounce_pulser #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_MODE       = 0,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] pulse_out
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   // Unsupported EDGE_MODE values fall back to rising-edge only.
   localparam logic RiseEn = (EDGE_MODE != 1);
   localparam logic FallEn = (EDGE_MODE == 1) || (EDGE_MODE == 2);

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW = $clog2(RepMax + 1);
   localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
   localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CntW-1:0]        cnt_d, cnt_q;
      logic                   level_d, level_q;
      logic                   pulse_d, pulse_q;
      logic                   sync_bit;
      logic                   rise, fall;
      logic                   rep_fire;

      assign sync_bit = sync_q[SYNC_STAGES-1];

      always_comb begin
         cnt_d   = '0;
         level_d = level_q;
         rise    = 1'b0;
         fall    = 1'b0;
         if (sync_bit != level_q) begin
            if (cnt_q == CntLast) begin
               level_d = ~level_q;
               rise    = ~level_q;
               fall    = level_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

`ifdef AUTO_REPEAT_EN
      logic [RepW-1:0] rep_d, rep_q;

      // Down-counter to the next repeat pulse; parked at zero while released.
      always_comb begin
         rep_d    = rep_q;
         rep_fire = 1'b0;
         if (rise) begin
            rep_d = RepDelayLast;
         end else if (!level_q || fall) begin
            rep_d = '0;
         end else if (rep_q == '0) begin
            rep_fire = RiseEn;
            rep_d    = RepPeriodLast;
         end else begin
            rep_d = rep_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rep_q <= '0;
         end else begin
            rep_q <= rep_d;
         end
      end
`else
      assign rep_fire = 1'b0;
`endif

      assign pulse_d = enable & ((rise & RiseEn) | (fall & FallEn) | rep_fire);

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
         end
      end

      assign level_out[i] = level_q;
      assign pulse_out[i] = pulse_q;
   end

endmodule

// File: tb/tb_multi_debounce_pulser.sv
// Scoreboard bench for multi_debounce_pulser: a window-based reference model predicts
// level/pulse for a rising-edge and a both-edge instance driven by the same stimulus.
module tb_multi_debounce_pulser;

   localparam int CH = 4;
   localparam int SS = 2;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam int HL = SS + DC;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic [CH-1:0] btn_in = '0;
   logic [CH-1:0] lvl_r, pls_r, lvl_b, pls_b;

   always #5 clk = ~clk;

   multi_debounce_pulser #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) u_dut_rise (
      .clk(clk), .reset(reset), .enable(enable), .btn_in(btn_in),
      .level_out(lvl_r), .pulse_out(pls_r)
   );

   multi_debounce_pulser #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) u_dut_both (
      .clk(clk), .reset(reset), .enable(enable), .btn_in(btn_in),
      .level_out(lvl_b), .pulse_out(pls_b)
   );

   typedef struct packed {
      logic [CH-1:0] lvl;
      logic [CH-1:0] pr;
      logic [CH-1:0] pb;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: raw input history (newest at index 0) and accepted levels.
   logic [CH-1:0] hist [HL];
   logic [CH-1:0] m_lvl = '0;
   int            rep_t [CH];

   task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s at %0t: got %b, want %b", name, $time, got, want);
      end
   endtask

   // Drive one cycle of stimulus and push the outputs expected after the next edge.
   task automatic step(input logic r, input logic en, input logic [CH-1:0] b);
      exp_t e;
      logic steady, rise, fall, fire;
      @(negedge clk);
      reset  = r;
      enable = en;
      btn_in = b;
      e.pr = '0;
      e.pb = '0;
      if (r) begin
         for (int k = 0; k < HL; k++) hist[k] = '0;
         m_lvl = '0;
         for (int c = 0; c < CH; c++) rep_t[c] = -1;
      end else begin
         for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = b;
         for (int c = 0; c < CH; c++) begin
            // Accept when the last DC synchronised samples all differ from the level.
            steady = 1'b1;
            for (int k = SS; k < HL; k++)
               if (hist[k][c] == m_lvl[c]) steady = 1'b0;
            rise = steady && !m_lvl[c];
            fall = steady && m_lvl[c];
            fire = 1'b0;
            if (steady) m_lvl[c] = ~m_lvl[c];
            if (rise) begin
               rep_t[c] = 0;
            end else if (fall || !m_lvl[c]) begin
               rep_t[c] = -1;
            end else begin
               rep_t[c]++;
`ifdef AUTO_REPEAT_EN
               fire = (rep_t[c] >= RD) && ((rep_t[c] - RD) % RP == 0);
`endif
            end
            e.pr[c] = en & (rise | fire);
            e.pb[c] = en & (rise | fall | fire);
         end
      end
      e.lvl = m_lvl;
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input logic en, input logic [CH-1:0] b);
      for (int k = 0; k < n; k++) step(1'b0, en, b);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("level_out rise-dut", lvl_r, e.lvl);
            chk("level_out both-dut", lvl_b, e.lvl);
            chk("pulse_out rise-dut", pls_r, e.pr);
            chk("pulse_out both-dut", pls_b, e.pb);
         end
      end
   end

   initial begin : stimulus
      logic [CH-1:0] b;
      logic          en, r;
      for (int c = 0; c < CH; c++) rep_t[c] = -1;
      for (int k = 0; k < HL; k++) hist[k] = '0;

      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, '0);
      // Clean press and release on channel 0.
      hold(20, 1'b1, 4'b0001);
      hold(12, 1'b1, 4'b0000);
      // Bounce on channel 1, then a steady press.
      hold(2, 1'b1, 4'b0010);
      hold(2, 1'b1, 4'b0000);
      hold(2, 1'b1, 4'b0010);
      hold(2, 1'b1, 4'b0000);
      hold(12, 1'b1, 4'b0010);
      hold(12, 1'b1, 4'b0000);
      // Simultaneous press on channels 0 and 3.
      hold(30, 1'b1, 4'b1001);
      hold(12, 1'b1, 4'b0000);
      // Press with enable low.
      hold(12, 1'b0, 4'b0100);
      hold(12, 1'b0, 4'b0000);
      // Reset pulse mid-debounce on a held input.
      hold(3, 1'b1, 4'b0001);
      step(1'b1, 1'b1, 4'b0001);
      hold(15, 1'b1, 4'b0001);
      hold(12, 1'b1, 4'b0000);
      // Long hold for auto-repeat.
      hold(60, 1'b1, 4'b0010);
      hold(12, 1'b1, 4'b0000);

      b = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 9) == 0) b[c] = ~b[c];
         en = ($urandom_range(0, 5) != 0);
         r  = ($urandom_range(0, 299) == 0);
         step(r, en, b);
      end
      hold(10, 1'b1, 4'b0000);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_debounce_pulser.md
Name: multi_debounce_pulser

Overview:
- Per-channel debounced single pulser for CHANNELS asynchronous, bouncy push-button/switch inputs.
- Each channel:
  - synchronises its input,
  - filters bounce with a stability counter,
  - emits a one-clock pulse on the selected edge(s) of the debounced level.
- Sits between the board I/O pins and the control FSMs that need exactly one event per press.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
- DEBOUNCE_CYCLES, 16, consecutive clocks a new level must persist before acceptance (>=1)
- EDGE_MODE, 0, edge that generates a pulse: 0 rising, 1 falling, 2 both
- REPEAT_DELAY, 1000, clocks from the press pulse to the first auto-repeat pulse (only used with AUTO_REPEAT_EN)
- REPEAT_PERIOD, 250, clocks between subsequent auto-repeat pulses (only used with AUTO_REPEAT_EN)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  high permits pulse_out; low forces pulse_out to 0 (filtering continues)
- btn_in  input  CHANNELS  raw asynchronous inputs, active high
- level_out  output  CHANNELS  debounced stable level per channel
- pulse_out  output  CHANNELS  one-clock event pulse per channel

Behaviour:
- Reset: reset and clock are fixed: reset is synchronous and active-high; clk is the clock.
  - While reset is high, all of the following are cleared to 0 at every clk edge: synchroniser flops, debounce counters, level_out, pulse_out and repeat timers.
- Channel independence: channels share no state; simultaneous activity on several channels is handled in parallel with identical timing.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops; the last stage is sync[i].
- Debounce, per channel:
  - When sync[i] == level_out[i], the counter is 0.
  - When sync[i] != level_out[i], the counter increments each clock.
  - On the clock where the counter would reach DEBOUNCE_CYCLES, level_out[i] toggles and the counter clears.
  - Counter width: clog2(DEBOUNCE_CYCLES+1); it never wraps.
  - Any return of sync[i] to level_out[i] before acceptance clears the counter. A glitch shorter than DEBOUNCE_CYCLES clocks produces no level change and no pulse.
- Latency: SYNC_STAGES + DEBOUNCE_CYCLES clock edges, counted from the first edge that samples a steady new btn_in value to the edge that updates level_out.
- Pulse:
  - Registered.
  - High for exactly one clock, in the same cycle level_out first shows the new value.
  - Generated only if the transition matches EDGE_MODE and enable is high on that edge.
  - A pulse suppressed by enable is lost, not deferred.
- Held input: no further pulses while the level stays constant (only first-press behaviour, unless AUTO_REPEAT_EN).
- Input high through reset release: level_out starts at 0. The channel therefore produces a rising event after the full latency.
- Reset mid-debounce: the in-progress count is discarded; no pulse is produced on the reset cycle.
- EDGE_MODE values outside 0..2 behave as 0.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Each channel has a repeat timer, cleared whenever level_out[i] is 0.
  - Timer starts on the rising-edge acceptance cycle.
  - First repeat pulse: REPEAT_DELAY clocks after the press pulse.
  - Subsequent repeat pulses: every REPEAT_PERIOD clocks while level_out[i] stays 1.
  - Repeat pulses obey enable. The timer keeps running while enable is low.
  - Releasing the input stops repeats immediately at the level_out fall.
  - Applies only when EDGE_MODE is 0 or 2.
- Undefined: no repeat logic or timers are synthesised; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_MODE=0; btn_in[0] 0->1 held 20 clocks -> level_out[0] rises exactly 6 edges after the first sampling edge; pulse_out[0]=1 for that single cycle; no pulse on release.
- Bounce rejection: btn_in[1] toggles 1,0,1,0 at 2-clock intervals, then holds 1 -> no pulse during bouncing; exactly one pulse 6 edges after the final steady 1.
- Both edges, multi-channel: EDGE_MODE=2; ch0 and ch3 pressed on the same clock and released 30 clocks later -> two pulses on each channel, cycle-aligned across channels; ch1 and ch2 stay 0.
- Enable gating and reset: enable=0 during a press -> level_out rises and pulse_out stays 0. Assert reset for 1 cycle mid-debounce on a held input -> all outputs 0; after reset release, the pulse appears after the full latency.
- Auto-repeat (AUTO_REPEAT_EN defined): REPEAT_DELAY=10, REPEAT_PERIOD=5, press held 30 clocks past acceptance -> pulses at acceptance, +10, +15, +20, +25, +30; release -> no further pulses.
